// File: rtl/multi_fifo_op_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_fifo_op_if
//  Purpose  : NUM_IN address-mapped input FIFOs feeding a combine stage that
//             pops one word from each input and pushes OR/AND/XOR/SUM of the
//             heads into a single output FIFO, read back over an en/rdy port.
//  Revision : 1.0  initial release
// ============================================================================
module multi_fifo_op_if #(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_rdy,
  output logic [NUM_IN-1:0] in_full_n,
  output logic              y_empty_n
);

  // Pointers carry one extra wrap bit so that full and empty differ.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  localparam logic [ADDR_W-1:0] c_addr_ctrl  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] c_addr_pop   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_mode  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] c_addr_count = ADDR_W'(3);
  localparam int                c_in_base    = 4;

  logic [NUM_IN-1:0] w_in_full;
  logic [NUM_IN-1:0] w_in_empty;
  logic [NUM_IN-1:0] w_in_sel;
  logic [DATA_W-1:0] w_heads [NUM_IN];

  logic              w_write_fire;
  logic              w_write_valid;
  logic              w_combine;
  logic              w_pop_y;
  logic              w_y_full;
  logic              w_y_empty;
  logic [PW-1:0]     w_y_count;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_status;

  logic [1:0]        r_mode;
  logic              r_err;

  logic [DATA_W-1:0] r_y_mem [DEPTH];
  logic [PW-1:0]     r_y_wr_ptr;
  logic [PW-1:0]     r_y_rd_ptr;

  // ------------------------------------------------------------------------
  // Write-side decode and handshake
  // ------------------------------------------------------------------------
  assign write_rdy     = ~(|(w_in_sel & w_in_full));
  assign w_write_fire  = write_en & write_rdy;
  assign w_write_valid = (write_address == c_addr_ctrl) |
                         (write_address == c_addr_mode) |
                         (|w_in_sel);

  // Combine only looks at start-of-cycle flags: no bypass through a FIFO.
  assign w_combine = ~(|w_in_empty) & ~w_y_full;

  // ------------------------------------------------------------------------
  // Input FIFOs, one per address 4+i
  // ------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      localparam logic [ADDR_W-1:0] c_addr = ADDR_W'(c_in_base + gi);

      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [PW-1:0]     r_wr_ptr;
      logic [PW-1:0]     r_rd_ptr;
      logic              w_push;

      assign w_in_sel[gi]   = (write_address == c_addr);
      assign w_push         = w_write_fire & w_in_sel[gi];
      assign w_in_empty[gi] = (r_wr_ptr == r_rd_ptr);
      assign w_in_full[gi]  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                              (r_wr_ptr[AW] != r_rd_ptr[AW]);
      assign w_heads[gi]    = r_mem[r_rd_ptr[AW-1:0]];

      // Pointer update: push from the write port, pop from the combine stage.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          if (w_push)    r_wr_ptr <= r_wr_ptr + PW'(1);
          if (w_combine) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end

      // Storage array; contents are don't-care while the FIFO is empty.
      always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= write_data;
      end
    end
  endgenerate

  assign in_full_n = ~w_in_full;

  // ------------------------------------------------------------------------
  // Combine function over all input heads, selected by the current mode
  // ------------------------------------------------------------------------
  // Fold the heads left to right with the operation chosen by r_mode.
  always_comb begin
    w_result = w_heads[0];
    for (int i = 1; i < NUM_IN; i++) begin
      case (r_mode)
        2'd0:    w_result = w_result | w_heads[i];
        2'd1:    w_result = w_result & w_heads[i];
        2'd2:    w_result = w_result ^ w_heads[i];
        default: w_result = w_result + w_heads[i];
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Output FIFO
  // ------------------------------------------------------------------------
  assign w_y_empty = (r_y_wr_ptr == r_y_rd_ptr);
  assign w_y_full  = (r_y_wr_ptr[AW-1:0] == r_y_rd_ptr[AW-1:0]) &&
                     (r_y_wr_ptr[AW] != r_y_rd_ptr[AW]);
  assign w_y_count = r_y_wr_ptr - r_y_rd_ptr;
  assign y_empty_n = ~w_y_empty;

  assign read_rdy = ~((read_address == c_addr_pop) & w_y_empty);
  assign w_pop_y  = read_en & read_rdy & (read_address == c_addr_pop);

  // Output pointers: combine pushes, a read of address 1 pops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_y_wr_ptr <= '0;
      r_y_rd_ptr <= '0;
    end else begin
      if (w_combine) r_y_wr_ptr <= r_y_wr_ptr + PW'(1);
      if (w_pop_y)   r_y_rd_ptr <= r_y_rd_ptr + PW'(1);
    end
  end

  // Output storage written with the combined word.
  always_ff @(posedge CLK) begin
    if (w_combine) r_y_mem[r_y_wr_ptr[AW-1:0]] <= w_result;
  end

  // ------------------------------------------------------------------------
  // Control registers: mode and sticky error
  // ------------------------------------------------------------------------
  // Mode write and error set/clear; a stalled write never reaches here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode <= 2'd0;
      r_err  <= 1'b0;
    end else if (w_write_fire) begin
      if (write_address == c_addr_mode) r_mode <= write_data[1:0];
      if (write_address == c_addr_ctrl) r_err  <= 1'b0;
      else if (!w_write_valid)          r_err  <= 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Read mux
  // ------------------------------------------------------------------------
  // Status word: {0, err, y_empty_n, in_full_n}.
  always_comb begin
    w_status             = '0;
    w_status[NUM_IN-1:0] = in_full_n;
    w_status[NUM_IN]     = y_empty_n;
    w_status[NUM_IN+1]   = r_err;
  end

  // Address-selected read value, purely combinational.
  always_comb begin
    read_data = '0;
    case (read_address)
      c_addr_ctrl:  read_data = w_status;
      c_addr_pop:   read_data = r_y_mem[r_y_rd_ptr[AW-1:0]];
      c_addr_mode:  read_data[1:0] = r_mode;
      c_addr_count: read_data = DATA_W'(w_y_count);
      default:      read_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_fifo_op_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_fifo_op_if
//  Purpose  : Self-checking bench for multi_fifo_op_if (NUM_IN=2, DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_fifo_op_if;

  localparam int DATA_W = 8;
  localparam int NUM_IN = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy;
  logic [ADDR_W-1:0] read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_rdy;
  logic [NUM_IN-1:0] in_full_n;
  logic              y_empty_n;

  multi_fifo_op_if #(
    .DATA_W(DATA_W), .NUM_IN(NUM_IN), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy),
    .in_full_n(in_full_n), .y_empty_n(y_empty_n)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] sb [$];

  typedef struct {
    logic [1:0]        mode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge CLK);
    write_address = a;
    write_data    = d;
    write_en      = 1'b1;
    @(negedge CLK);
    write_en      = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic r);
    @(negedge CLK);
    read_address = a;
    read_en      = 1'b1;
    #1;
    d = read_data;
    r = read_rdy;
    @(negedge CLK);
    read_en = 1'b0;
  endtask

  task automatic peek(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    read_address = a;
    #1;
    d = read_data;
  endtask

  task automatic pop_check(input string name);
    logic [DATA_W-1:0] d;
    logic r;
    rd(4'd1, d, r);
    check({name, "_rdy"}, 32'(r), 32'd1);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: got 0x%0h expected no output", name, d);
    end else begin
      check({name, "_data"}, 32'(d), 32'(sb.pop_front()));
    end
  endtask

  // Watchdog: the sequence below is bounded, this only guards against a stall.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] d;
    vecs[0] = '{2'd1, 8'hF0, 8'h3C, 8'h30};
    vecs[1] = '{2'd2, 8'hF0, 8'h3C, 8'hCC};
    vecs[2] = '{2'd3, 8'hF0, 8'h3C, 8'h2C};
    vecs[3] = '{2'd3, 8'hFF, 8'h02, 8'h01};
    vecs[4] = '{2'd0, 8'hA0, 8'h05, 8'hA5};

    RST_N = 1'b0;
    write_address = '0; write_data = '0; write_en = 1'b0;
    read_address  = '0; read_en = 1'b0;

    // Reset state, checked before any clock edge (asynchronous reset).
    #1;
    check("rst_in_full_n", 32'(in_full_n), 32'h3);
    check("rst_y_empty_n", 32'(y_empty_n), 32'h0);
    check("rst_write_rdy", 32'(write_rdy), 32'h1);
    peek(4'd0, d);  check("rst_status", 32'(d), 32'h03);
    check("rst_read_rdy0", 32'(read_rdy), 32'h1);
    peek(4'd2, d);  check("rst_mode", 32'(d), 32'h0);
    peek(4'd1, d);  check("rst_read_rdy1", 32'(read_rdy), 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Basic OR combine and its one-cycle latency.
    wr(4'd4, 8'h0C);
    wr(4'd5, 8'h03);
    sb.push_back(8'h0F);
    check("lat_before", 32'(y_empty_n), 32'h0);
    @(negedge CLK);
    check("lat_after", 32'(y_empty_n), 32'h1);
    pop_check("or_basic");
    peek(4'd1, d);
    check("drained_read_rdy", 32'(read_rdy), 32'h0);

    // Table of modes, including the additive wrap.
    for (int i = 0; i < 5; i++) begin
      wr(4'd2, DATA_W'(vecs[i].mode));
      wr(4'd4, vecs[i].a);
      wr(4'd5, vecs[i].b);
      sb.push_back(vecs[i].exp);
      repeat (2) @(negedge CLK);
      peek(4'd2, d);
      check($sformatf("mode_rb%0d", i), 32'(d), 32'(vecs[i].mode));
      pop_check($sformatf("vec%0d", i));
    end

    // Input backpressure: fill input 0 only (mode is OR now).
    wr(4'd4, 8'h01); wr(4'd4, 8'h02); wr(4'd4, 8'h04); wr(4'd4, 8'h08);
    write_address = 4'd4;
    #1;
    check("bp_write_rdy", 32'(write_rdy), 32'h0);
    check("bp_in_full_n", 32'(in_full_n), 32'h2);
    wr(4'd4, 8'h55);                       // stalled: no push, no err
    peek(4'd0, d);  check("bp_status", 32'(d), 32'h02);
    wr(4'd5, 8'h10);
    sb.push_back(8'h11);
    check("bp_full_hold", 32'(in_full_n), 32'h2);
    @(negedge CLK);
    check("bp_full_release", 32'(in_full_n), 32'h3);

    // Output full: three more combines fill the output FIFO.
    wr(4'd5, 8'h20); sb.push_back(8'h22);
    wr(4'd5, 8'h40); sb.push_back(8'h44);
    wr(4'd5, 8'h80); sb.push_back(8'h88);
    repeat (2) @(negedge CLK);
    peek(4'd3, d);  check("of_count_full", 32'(d), 32'd4);
    wr(4'd4, 8'h01);
    wr(4'd5, 8'h02);
    sb.push_back(8'h03);
    repeat (2) @(negedge CLK);
    peek(4'd3, d);  check("of_count_stall", 32'(d), 32'd4);
    peek(4'd0, d);  check("of_status", 32'(d), 32'h07);
    pop_check("of_pop0");
    peek(4'd3, d);  check("of_count_after_pop", 32'(d), 32'd3);
    @(negedge CLK);
    peek(4'd3, d);  check("of_count_refill", 32'(d), 32'd4);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("of_pop%0d", i));
    peek(4'd1, d);
    check("of_empty_read_rdy", 32'(read_rdy), 32'h0);

    // Sticky error and clear.
    wr(4'd1, 8'h00);
    peek(4'd0, d);  check("err_set_a1", 32'(d), 32'h0B);
    wr(4'd0, 8'h00);
    peek(4'd0, d);  check("err_clr_a1", 32'(d), 32'h03);
    wr(4'd7, 8'h00);
    peek(4'd0, d);  check("err_set_a7", 32'(d), 32'h0B);
    wr(4'd0, 8'h00);
    peek(4'd0, d);  check("err_clr_a7", 32'(d), 32'h03);

    // Reset mid-stream with two words in the output FIFO (mode 3).
    wr(4'd2, 8'h03);
    wr(4'd4, 8'h01); wr(4'd5, 8'h01); sb.push_back(8'h02);
    wr(4'd4, 8'h02); wr(4'd5, 8'h02); sb.push_back(8'h04);
    repeat (2) @(negedge CLK);
    peek(4'd3, d);  check("mr_count_before", 32'(d), 32'd2);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("mr_y_empty_n", 32'(y_empty_n), 32'h0);
    peek(4'd3, d);  check("mr_count", 32'(d), 32'd0);
    peek(4'd2, d);  check("mr_mode", 32'(d), 32'd0);
    peek(4'd0, d);  check("mr_status", 32'(d), 32'h03);
    sb.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    peek(4'd1, d);
    check("mr_read_rdy", 32'(read_rdy), 32'h0);
    wr(4'd4, 8'h05);
    wr(4'd5, 8'h0A);
    sb.push_back(8'h0F);
    repeat (2) @(negedge CLK);
    pop_check("mr_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
